// File: rtl/matrix_elem_sender_pkg.sv
// Shared definitions for the matrix element sender: element type, ASCII
// constants used when formatting numbers, and the sender state encoding.
package matrix_elem_sender_pkg;

  localparam int ELEM_W    = 8;
  localparam int BUF_DEPTH = 8;

  typedef logic signed [ELEM_W-1:0] matrix_element_t;

  localparam logic [7:0] ASC_SPACE = 8'h20;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;
  localparam logic [7:0] ASC_MINUS = 8'h2D;
  localparam logic [7:0] ASC_LBRK  = 8'h5B;
  localparam logic [7:0] ASC_RBRK  = 8'h5D;
  localparam logic [7:0] ASC_ZERO  = 8'h30;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_WAIT_ACK,
    S_WAIT_IDLE,
    S_NEXT,
    S_DONE
  } sender_state_t;

endpackage

// File: rtl/matrix_elem_sender_elem_to_ascii.sv
// Splits a signed element into sign flag and up to three ASCII decimal
// digits. The magnitude is taken one bit wider than the element so that
// the most negative value (e.g. -128) converts correctly.
module elem_to_ascii #(
  parameter int ELEM_W = 8
) (
  input  logic signed [ELEM_W-1:0] elem,
  output logic [7:0]               hund_ch,
  output logic [7:0]               tens_ch,
  output logic [7:0]               ones_ch,
  output logic [1:0]               num_digits,
  output logic                     is_neg
);
  import matrix_elem_sender_pkg::*;

  logic signed [ELEM_W:0] ext;
  logic [ELEM_W:0]        mag;
  logic [8:0]             mag9;
  logic [3:0]             hund_d;
  logic [3:0]             tens_d;
  logic [3:0]             ones_d;

  // Sign/magnitude split followed by constant-divisor digit extraction
  always_comb begin
    is_neg     = elem[ELEM_W-1];
    ext        = {elem[ELEM_W-1], elem};
    mag        = is_neg ? $unsigned(-ext) : $unsigned(ext);
    mag9       = 9'(mag);
    hund_d     = 4'(mag9 / 9'd100);
    tens_d     = 4'((mag9 / 9'd10) % 9'd10);
    ones_d     = 4'(mag9 % 9'd10);
    hund_ch    = ASC_ZERO + {4'h0, hund_d};
    tens_ch    = ASC_ZERO + {4'h0, tens_d};
    ones_ch    = ASC_ZERO + {4'h0, ones_d};
    num_digits = (mag9 >= 9'd100) ? 2'd3 : ((mag9 >= 9'd10) ? 2'd2 : 2'd1);
  end

endmodule

// File: rtl/matrix_elem_sender.sv
// Formats one signed matrix element (or a bare newline) as ASCII text and
// streams it byte-by-byte into a UART transmitter.
//
// UART handshake: tx_start is a one-cycle strobe issued only after tx_busy
// has been observed low; tx_data is valid in the strobe cycle and held until
// the next byte is loaded. After a strobe the sender waits up to two cycles
// for tx_busy to rise (a transmitter that never raises it is taken as having
// accepted the byte) and then for tx_busy to fall before the next strobe.
module matrix_elem_sender #(
  parameter int ELEM_W    = 8,
  parameter int BUF_DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [ELEM_W-1:0] sender_data,
  input  logic                     sender_start,
  input  logic                     sender_is_last_col,
  input  logic                     sender_newline_only,
  input  logic                     sender_id,
  output logic                     sender_done,
  output logic                     busy,
  output logic [7:0]               tx_data,
  output logic                     tx_start,
  input  logic                     tx_busy
);
  import matrix_elem_sender_pkg::*;

  localparam int IDX_W = $clog2(BUF_DEPTH);
  localparam int LEN_W = $clog2(BUF_DEPTH + 1);
  localparam int BUF_W = BUF_DEPTH * 8;

  sender_state_t            state;
  logic signed [ELEM_W-1:0] data_q;
  logic                     last_q;
  logic                     nl_q;
  logic                     id_q;
  logic [BUF_W-1:0]         buf_q;
  logic [LEN_W-1:0]         len_q;
  logic [IDX_W-1:0]         idx;
  logic                     ack_cnt;

  logic [7:0]               hund_ch;
  logic [7:0]               tens_ch;
  logic [7:0]               ones_ch;
  logic [1:0]               num_digits;
  logic                     is_neg;

  logic [BUF_W-1:0]         pack_buf;
  logic [LEN_W-1:0]         pack_len;
  logic [IDX_W-1:0]         idx_nxt;

  elem_to_ascii #(
    .ELEM_W (ELEM_W)
  ) u_elem_to_ascii (
    .elem       (data_q),
    .hund_ch    (hund_ch),
    .tens_ch    (tens_ch),
    .ones_ch    (ones_ch),
    .num_digits (num_digits),
    .is_neg     (is_neg)
  );

  // Positions a character at slot pos of the packed buffer
  function automatic logic [BUF_W-1:0] place(input logic [7:0] ch,
                                             input logic [LEN_W-1:0] pos);
    return BUF_W'(ch) << {pos, 3'b000};
  endfunction

  // Pack the latched request into characters, first character in slot 0
  always_comb begin
    pack_buf = '0;
    pack_len = '0;
    if (nl_q) begin
      pack_buf = place(ASC_CR, LEN_W'(0)) | place(ASC_LF, LEN_W'(1));
      pack_len = LEN_W'(2);
    end else begin
      if (id_q) begin
        pack_buf = pack_buf | place(ASC_LBRK, pack_len);
        pack_len = pack_len + LEN_W'(1);
      end
      if (is_neg) begin
        pack_buf = pack_buf | place(ASC_MINUS, pack_len);
        pack_len = pack_len + LEN_W'(1);
      end
      if (num_digits == 2'd3) begin
        pack_buf = pack_buf | place(hund_ch, pack_len);
        pack_len = pack_len + LEN_W'(1);
      end
      if (num_digits >= 2'd2) begin
        pack_buf = pack_buf | place(tens_ch, pack_len);
        pack_len = pack_len + LEN_W'(1);
      end
      pack_buf = pack_buf | place(ones_ch, pack_len);
      pack_len = pack_len + LEN_W'(1);
      if (id_q) begin
        pack_buf = pack_buf | place(ASC_RBRK, pack_len);
        pack_len = pack_len + LEN_W'(1);
      end
      if (last_q) begin
        pack_buf = pack_buf | place(ASC_CR, pack_len);
        pack_len = pack_len + LEN_W'(1);
        pack_buf = pack_buf | place(ASC_LF, pack_len);
        pack_len = pack_len + LEN_W'(1);
      end else begin
        pack_buf = pack_buf | place(ASC_SPACE, pack_len);
        pack_len = pack_len + LEN_W'(1);
      end
    end
  end

  assign idx_nxt = idx + IDX_W'(1);

  // Sender FSM; every output is a register updated here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      data_q      <= '0;
      last_q      <= 1'b0;
      nl_q        <= 1'b0;
      id_q        <= 1'b0;
      buf_q       <= '0;
      len_q       <= '0;
      idx         <= '0;
      ack_cnt     <= 1'b0;
      sender_done <= 1'b0;
      busy        <= 1'b0;
      tx_data     <= 8'h00;
      tx_start    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (sender_start) begin
            data_q <= sender_data;
            last_q <= sender_is_last_col;
            nl_q   <= sender_newline_only;
            id_q   <= sender_id;
            busy   <= 1'b1;
            state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          // The first strobe is issued straight out of LOAD when the UART is free
          buf_q    <= pack_buf;
          len_q    <= pack_len;
          idx      <= '0;
          tx_data  <= pack_buf[7:0];
          tx_start <= !tx_busy;
          state    <= S_SEND;
        end
        S_SEND: begin
          if (tx_start) begin
            tx_start <= 1'b0;
            ack_cnt  <= 1'b0;
            state    <= S_WAIT_ACK;
          end else if (!tx_busy) begin
            tx_start <= 1'b1;
          end
        end
        S_WAIT_ACK: begin
          if (tx_busy || ack_cnt) begin
            state <= S_WAIT_IDLE;
          end else begin
            ack_cnt <= 1'b1;
          end
        end
        S_WAIT_IDLE: begin
          if (!tx_busy) begin
            state <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (LEN_W'(idx) == len_q - LEN_W'(1)) begin
            sender_done <= 1'b1;
            state       <= S_DONE;
          end else begin
            idx      <= idx_nxt;
            tx_data  <= buf_q[{idx_nxt, 3'b000} +: 8];
            tx_start <= !tx_busy;
            state    <= S_SEND;
          end
        end
        S_DONE: begin
          sender_done <= 1'b0;
          busy        <= 1'b0;
          idx         <= '0;
          state       <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_elem_sender.sv
// Directed bench for matrix_elem_sender with a small UART transmitter model
// and a byte scoreboard.
module tb_matrix_elem_sender;
  import matrix_elem_sender_pkg::*;

  localparam int FRAME  = 6;
  localparam int BUDGET = 600;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] sender_data = 8'h00;
  logic       sender_start = 1'b0;
  logic       sender_is_last_col = 1'b0;
  logic       sender_newline_only = 1'b0;
  logic       sender_id = 1'b0;
  logic       sender_done;
  logic       busy;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;

  always #5 clk = ~clk;

  matrix_elem_sender dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .sender_data         (sender_data),
    .sender_start        (sender_start),
    .sender_is_last_col  (sender_is_last_col),
    .sender_newline_only (sender_newline_only),
    .sender_id           (sender_id),
    .sender_done         (sender_done),
    .busy                (busy),
    .tx_data             (tx_data),
    .tx_start            (tx_start),
    .tx_busy             (tx_busy)
  );

  // ---------------- scoreboard state ----------------
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         done_cnt = 0;
  int         busy_cnt = 0;
  logic       force_busy = 1'b0;
  logic       noack = 1'b0;

  assign tx_busy = force_busy || (busy_cnt != 0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // UART model: captures each strobe, then stays busy for a frame
  always @(negedge clk) begin
    if (tx_start) begin
      chk("strobe_while_busy", 32'(tx_busy), 32'd0);
      got_q.push_back(tx_data);
      if (!noack) busy_cnt = FRAME;
    end else if (busy_cnt > 0) begin
      busy_cnt = busy_cnt - 1;
    end
  end

  // Count cycles with sender_done high
  always @(posedge clk) begin
    if (sender_done) done_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic start_req(input logic [7:0] d, input logic last, input logic nl, input logic id);
    @(negedge clk);
    sender_data         = d;
    sender_is_last_col  = last;
    sender_newline_only = nl;
    sender_id           = id;
    sender_start        = 1'b1;
    @(negedge clk);
    sender_start        = 1'b0;
    sender_data         = 8'($urandom_range(0, 255));
    sender_is_last_col  = 1'($urandom_range(0, 1));
    sender_newline_only = 1'($urandom_range(0, 1));
    sender_id           = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (sender_done !== 1'b1 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, 32'(sender_done), 32'd1);
  endtask

  task automatic wait_bytes(input string tag, input int k);
    int n = 0;
    while (got_q.size() < k && n < BUDGET) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_bytes_arrived"}, 32'(got_q.size() >= k), 32'd1);
  endtask

  task automatic check_bytes(input string tag, input int d0, input int exp_done);
    @(posedge clk);
    #1;
    chk({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) chk($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    end
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    chk({tag, "_done_count"}, 32'(done_cnt - d0), 32'(exp_done));
    exp_q.delete();
    got_q.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int d0;
    int n;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(sender_done), 32'd0);
    rst_n = 1'b1;

    // 1: zero, space terminator, latency to first strobe
    d0 = done_cnt;
    start_req(8'h00, 1'b0, 1'b0, 1'b0);
    chk("t1_lat_c1_strobe", 32'(tx_start), 32'd0);
    chk("t1_lat_c1_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("t1_lat_c2_strobe", 32'(tx_start), 32'd1);
    chk("t1_lat_c2_data", 32'(tx_data), 32'h30);
    wait_done("t1");
    exp_q = '{8'h30, 8'h20};
    check_bytes("t1", d0, 1);

    // 2: most negative value, row end
    d0 = done_cnt;
    start_req(8'h80, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("t2_first_data", 32'(tx_data), 32'h2D);
    wait_done("t2");
    exp_q = '{8'h2D, 8'h31, 8'h32, 8'h38, 8'h0D, 8'h0A};
    check_bytes("t2", d0, 1);

    // 3: ID-tagged maximum value, row end
    d0 = done_cnt;
    start_req(8'h7F, 1'b1, 1'b0, 1'b1);
    wait_done("t3");
    exp_q = '{8'h5B, 8'h31, 8'h32, 8'h37, 8'h5D, 8'h0D, 8'h0A};
    check_bytes("t3", d0, 1);

    // 4: newline-only overrides data and id
    d0 = done_cnt;
    start_req(8'hFB, 1'b0, 1'b1, 1'b1);
    wait_done("t4");
    exp_q = '{8'h0D, 8'h0A};
    check_bytes("t4", d0, 1);

    // 5: UART busy for 50 cycles, plus an ignored start mid-transfer
    d0 = done_cnt;
    force_busy = 1'b1;
    start_req(8'hF9, 1'b0, 1'b0, 1'b0);
    n = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx_start) n++;
    end
    chk("t5_no_strobe_while_busy", 32'(n), 32'd0);
    force_busy = 1'b0;
    wait_bytes("t5", 1);
    @(negedge clk);
    sender_data  = 8'h63;
    sender_start = 1'b1;
    @(negedge clk);
    sender_start = 1'b0;
    wait_done("t5");
    exp_q = '{8'h2D, 8'h37, 8'h20};
    check_bytes("t5", d0, 1);
    repeat (10) @(negedge clk);
    chk("t5_no_extra_bytes", 32'(got_q.size()), 32'd0);
    chk("t5_idle_busy", 32'(busy), 32'd0);

    // 6a: reset in the middle of "-45 "
    d0 = done_cnt;
    start_req(8'hD3, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (!(got_q.size() == 2 && tx_start === 1'b1) && n < BUDGET) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("t6a_third_strobe_seen", 32'(tx_start), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6a_rst_strobe", 32'(tx_start), 32'd0);
    chk("t6a_rst_busy", 32'(busy), 32'd0);
    repeat (20) @(negedge clk);
    chk("t6a_no_done", 32'(done_cnt - d0), 32'd0);
    exp_q = '{8'h2D, 8'h34};
    chk("t6a_len", 32'(got_q.size()), 32'd2);
    if (got_q.size() == 2) begin
      chk("t6a_byte0", 32'(got_q[0]), 32'(exp_q[0]));
      chk("t6a_byte1", 32'(got_q[1]), 32'(exp_q[1]));
    end
    exp_q.delete();
    got_q.delete();
    rst_n = 1'b1;
    d0 = done_cnt;
    start_req(8'h09, 1'b0, 1'b0, 1'b0);
    wait_done("t6a_fresh");
    exp_q = '{8'h39, 8'h20};
    check_bytes("t6a_fresh", d0, 1);

    // 6b: back-to-back requests, second accepted right after done
    d0 = done_cnt;
    start_req(8'h01, 1'b0, 1'b0, 1'b0);
    wait_done("t6b_first");
    start_req(8'h02, 1'b0, 1'b0, 1'b0);
    chk("t6b_second_accepted", 32'(busy), 32'd1);
    wait_done("t6b_second");
    exp_q = '{8'h31, 8'h20, 8'h32, 8'h20};
    check_bytes("t6b", d0, 2);

    // 7: transmitter that never raises tx_busy
    noack = 1'b1;
    d0 = done_cnt;
    start_req(8'h05, 1'b0, 1'b0, 1'b0);
    wait_done("t7");
    exp_q = '{8'h35, 8'h20};
    check_bytes("t7", d0, 1);
    noack = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog against a hung sequence
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/matrix_elem_sender.md
Name: matrix_elem_sender

Overview:
- Downstream consumer of the matrix input, display and echo stages.
- Takes one signed matrix element per request and formats it as decimal ASCII text.
- Streams the characters byte-by-byte into the UART transmitter, adding a separator (space, or CR LF at row end).
- Also serves newline-only requests and ID-tagged requests ("[n]" format); signals completion with a one-cycle done pulse.

Parameters:
ELEM_W, 8, element width in bits, two's complement; the formatter supports 2..8 (max magnitude 128, three digits).
BUF_DEPTH, 8, character buffer slots; the worst case is "[-128]\r\n" = 8.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
sender_data  in  ELEM_W  signed element to print (matrix_element_t)
sender_start  in  1  one-cycle request pulse
sender_is_last_col  in  1  terminator select: 1 = CR LF, 0 = space
sender_newline_only  in  1  emit CR LF only; data ignored
sender_id  in  1  wrap digits in '[' ']'
sender_done  out  1  one-cycle pulse after the last byte has finished transmitting
busy  out  1  high from the accepted start until done
tx_data  out  8  byte to the UART transmitter
tx_start  out  1  one-cycle transmit strobe
tx_busy  in  1  UART transmitter busy

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: all outputs 0; FSM in IDLE; buffer, length and index registers 0.
- Reset asserted mid-operation: the current request is aborted immediately and no done pulse is produced. tx_start drops at once; a byte already inside the UART is not recalled.

Request acceptance:
- A request is accepted only in IDLE, on a cycle with sender_start=1.
- On acceptance, data, is_last_col, newline_only and id are latched. Later changes to these inputs have no effect on the request.
- sender_start while busy=1 is ignored: not queued, no error.

FSM states: IDLE, LOAD, SEND, WAIT_ACK, WAIT_IDLE, NEXT, DONE.
- IDLE: on start, go to LOAD; busy=1 from the next cycle.
- LOAD (1 cycle): fill the buffer and length register.
  - newline_only: "\r\n", length 2.
  - Otherwise, in order: optional '[' (id); '-' if data<0; magnitude digits with no leading zeros (0 gives "0"); optional ']' (id); then " " or "\r\n".
  - Magnitude is computed at ELEM_W+1 bits, so -128 gives 128.
  - Go to SEND.
- SEND: wait until tx_busy=0, then drive tx_data=buf[idx] and tx_start=1 for exactly one cycle; go to WAIT_ACK.
- WAIT_ACK: wait for tx_busy=1, capped at 2 cycles; if tx_busy never rises, treat the byte as sent. Go to WAIT_IDLE.
- WAIT_IDLE: wait for tx_busy=0; go to NEXT.
- NEXT: if idx==length-1, go to DONE; otherwise idx+1 and go to SEND.
- DONE: sender_done=1 for one cycle; busy=0 from the following cycle; idx cleared; go to IDLE.

Timing and flow rules:
- Latency: the first tx_start comes 2 cycles after the start cycle, provided tx_busy=0.
- Total duration ≈ length × UART frame time.
- tx_data holds its value from the tx_start cycle until the next byte is loaded.
- Exactly one tx_start per buffered character; never two tx_start pulses without an intervening tx_busy-low observation.
- Flag priority: newline_only overrides id and is_last_col. id combines with is_last_col.
- A new request may be accepted in the cycle after the done pulse, which allows back-to-back echo.

Decomposition:
- The shared project package holds:
  - matrix_element_t and ELEM_W;
  - ASCII constants ASC_SPACE=8'h20, ASC_CR=8'h0D, ASC_LF=8'h0A, ASC_MINUS=8'h2D, ASC_LBRK=8'h5B, ASC_RBRK=8'h5D, ASC_ZERO=8'h30;
  - the sender state typedef.
- One combinational sub-module, elem_to_ascii: signed element in; hundreds/tens/ones digits, digit count and sign flag out, with the digits already in ASCII. The buffer-packing logic stays in the parent.

Test Plan:
1. data=0, last_col=0 -> bytes 30 20; one done pulse; busy low afterwards.
2. data=-128, last_col=1 -> bytes 2D 31 32 38 0D 0A.
3. data=127, id=1, last_col=1 -> bytes 5B 31 32 37 5D 0D 0A.
4. newline_only=1, data=-5, id=1 -> bytes 0D 0A only.
5. data=-7 with tx_busy forced high for 50 cycles before the first byte -> no tx_start until tx_busy falls. Output is 2D 37 20. A second sender_start mid-transfer produces no extra bytes and only one done pulse.
6. Two sequences:
   - Assert rst_n low after the second byte of "-45 " -> tx_start and busy go to 0 at once, no done pulse. A fresh request of 9 with last_col=0 then yields 39 20.
   - Back-to-back requests 1 then 2 -> 31 20 32 20, two done pulses.
